dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters: the CPU load/store port and an auxiliary port used by the program loader and debug.
- Performs the data-memory address mapping: word address into the upper half of the 512-word RAM; byte address 0x0000 is the memory-mapped I/O register.
- Sequences the one-cycle RAM read latency and steers returned data to the requester that owns it.
- Fixed CPU priority, with a starvation guard for the auxiliary port.

Parameters:
- MAX_WAIT, 4: consecutive cycles the aux port may be denied before it gets forced priority (1..15).
- RAM_BANK, 1: value driven on mem_addr[8], i.e. which half of the raw RAM holds data memory.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  CPU byte address
- cpu_wdata  in  16  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  16  CPU read data
- aux_req / aux_we / aux_addr / aux_wdata  in  1/1/16/16  aux request, same meaning as the CPU fields
- aux_gnt / aux_rvalid / aux_rdata  out  1/1/16  aux response, same meaning as the CPU fields
- io_in  in  16  external input word, read at address 0
- io_out  out  16  registered output word, written at address 0
- mem_addr  out  9  raw RAM word address
- mem_data  out  16  raw RAM write data
- mem_we  out  1  raw RAM write enable
- mem_q  in  16  raw RAM read data, valid one cycle after its address is presented

Behaviour:
- Reset (async, reset_n=0) clears:
  - cpu_rvalid, aux_rvalid, io_out, the starvation counter, the pending-read owner and the I/O-read flag;
  - cpu_rdata and aux_rdata go to 0.
  - A read in flight when reset asserts is dropped; no rvalid follows reset release.
- Arbitration is combinational within the cycle; the grant lasts one cycle; at most one grant per cycle.
  - Only one requester: it is granted.
  - Both request: CPU wins, unless wait_cnt == MAX_WAIT, in which case aux wins.
  - A requester holds req and all its fields until it sees gnt; fields are sampled in the grant cycle.
- wait_cnt (4-bit):
  - +1 when aux_req=1 and aux_gnt=0, saturating at MAX_WAIT;
  - cleared when aux_gnt=1 or aux_req=0.
- Mapping of the granted request (addr):
  - addr == 0x0000 (I/O):
    - write: io_out <= wdata at the clock edge; mem_we=0, mem_data=0.
    - read: io_in is captured at the edge and returned next cycle.
  - otherwise:
    - mem_addr = {RAM_BANK, addr[8:1]}, mem_data = wdata, mem_we = we.
    - addr[0] is ignored.
    - addr[15:9] are ignored, so the space aliases every 0x200 bytes.
    - 0x0001 maps to word {RAM_BANK, 8'h00}.
- With no grant: mem_we=0, mem_addr=0, mem_data=0.
- Read latency is exactly 1 cycle:
  - rvalid of the granted port is 1 in the cycle after the grant;
  - rdata is mem_q, or the captured io_in for address 0;
  - rdata is held until the next read of that port completes.
- Writes produce no rvalid.
- Back-to-back grants every cycle are allowed. A read granted immediately after a write to the same word returns the new data, which relies on the RAM's write-then-read ordering across cycles.
- Response routing uses a registered owner bit, so an aux read followed by a CPU read returns each result to its own port on consecutive cycles.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined: adds output range_err (1 bit, registered, reset 0), which pulses for 1 cycle after a granted access with addr[15:9] != 0.
  - That write is suppressed (mem_we=0).
  - That read returns 0x0000 with a normal rvalid.
- Undefined: no range_err port; aliasing applies as described in Behaviour.

Test Plan:
- Reset: hold reset_n=0 while aux is mid-read, then release → all rvalid=0, io_out=0x0000, no stray rvalid after release.
- CPU write 0x1234 to 0x0010, then read 0x0010 → mem_addr=0x108, mem_we=1 in the write cycle; cpu_rvalid=1 with cpu_rdata=0x1234 one cycle after the read grant.
- I/O path: CPU write 0xBEEF to 0x0000 → io_out=0xBEEF and mem_we stays 0. With io_in=0x00A5, aux read of 0x0000 → aux_rdata=0x00A5 after 1 cycle.
- Contention: cpu_req and aux_req both held high continuously, MAX_WAIT=4 → CPU granted 4 cycles, aux granted on cycle 5, wait_cnt returns to 0, pattern repeats.
- Interleaved reads: aux reads 0x0020 (holds 0x1111), next cycle CPU reads 0x0022 (holds 0x2222) → aux_rdata=0x1111, then cpu_rdata=0x2222, no cross-delivery.
- Aliasing: write 0x5555 to 0x0204 → mem_addr=0x102. With DMEM_RANGE_CHECK_EN defined, the same write gives range_err=1 for 1 cycle and mem_we=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: CPU/aux sharing with starvation guard, address mapping, I/O word at 0x0000.
// Optional macro DMEM_RANGE_CHECK_EN adds range_err and blocks accesses with addr[15:9] != 0.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter bit          RAM_BANK = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [15:0] aux_addr,
  input  logic [15:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [15:0] aux_rdata,
`ifdef DMEM_RANGE_CHECK_EN
  output logic        range_err,
`endif
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic [8:0]  mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  input  logic [15:0] mem_q
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        owner_q, owner_d;
  logic        io_rd_q, io_rd_d;
  logic        zero_rd_q, zero_rd_d;
  logic        range_err_q, range_err_d;
  logic [15:0] io_cap_q, io_cap_d;
  logic [15:0] io_out_q, io_out_d;
  logic [15:0] cpu_hold_q, cpu_hold_d;
  logic [15:0] aux_hold_q, aux_hold_d;

  logic        cpu_gnt_s, aux_gnt_s, g_valid_s, g_we_s, g_io_s, g_oor_s;
  logic [15:0] g_addr_s, g_wdata_s, resp_data_s;

  // Arbitration, starvation counter and selection of the granted request
  always_comb begin
    cpu_gnt_s = cpu_req & ~(aux_req & (wait_cnt_q == MAX_WAIT_C));
    aux_gnt_s = aux_req & ~cpu_gnt_s;
    g_valid_s = cpu_gnt_s | aux_gnt_s;
    if (aux_req && !aux_gnt_s) begin
      if (wait_cnt_q == MAX_WAIT_C) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end else begin
      wait_cnt_d = 4'd0;
    end
    if (aux_gnt_s) begin
      g_we_s    = aux_we;
      g_addr_s  = aux_addr;
      g_wdata_s = aux_wdata;
    end else begin
      g_we_s    = cpu_we;
      g_addr_s  = cpu_addr;
      g_wdata_s = cpu_wdata;
    end
    g_io_s = g_valid_s & (g_addr_s == 16'h0000);
`ifdef DMEM_RANGE_CHECK_EN
    g_oor_s = g_valid_s & (g_addr_s[15:9] != 7'd0);
`else
    g_oor_s = 1'b0;
`endif
  end

  // Raw RAM port drive; address 0 and idle cycles leave the RAM untouched
  always_comb begin
    mem_we = g_valid_s & g_we_s & ~g_io_s & ~g_oor_s;
    if (g_valid_s && !g_io_s) begin
      mem_addr = {RAM_BANK, g_addr_s[8:1]};
      mem_data = g_wdata_s;
    end else begin
      mem_addr = 9'd0;
      mem_data = 16'd0;
    end
  end

  // Next state of the read pipeline, I/O register and held read data
  always_comb begin
    rd_pend_d   = g_valid_s & ~g_we_s;
    owner_d     = aux_gnt_s;
    io_rd_d     = g_io_s & ~g_we_s;
    zero_rd_d   = g_oor_s & ~g_we_s;
    range_err_d = g_oor_s;
    if (g_io_s && !g_we_s) begin
      io_cap_d = io_in;
    end else begin
      io_cap_d = io_cap_q;
    end
    if (g_io_s && g_we_s) begin
      io_out_d = g_wdata_s;
    end else begin
      io_out_d = io_out_q;
    end
    if (io_rd_q) begin
      resp_data_s = io_cap_q;
    end else if (zero_rd_q) begin
      resp_data_s = 16'h0000;
    end else begin
      resp_data_s = mem_q;
    end
    if (rd_pend_q && !owner_q) begin
      cpu_hold_d = resp_data_s;
    end else begin
      cpu_hold_d = cpu_hold_q;
    end
    if (rd_pend_q && owner_q) begin
      aux_hold_d = resp_data_s;
    end else begin
      aux_hold_d = aux_hold_q;
    end
  end

  // State registers; reset drops any read in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q  <= 4'd0;
      rd_pend_q   <= 1'b0;
      owner_q     <= 1'b0;
      io_rd_q     <= 1'b0;
      zero_rd_q   <= 1'b0;
      range_err_q <= 1'b0;
      io_cap_q    <= 16'd0;
      io_out_q    <= 16'd0;
      cpu_hold_q  <= 16'd0;
      aux_hold_q  <= 16'd0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rd_pend_q   <= rd_pend_d;
      owner_q     <= owner_d;
      io_rd_q     <= io_rd_d;
      zero_rd_q   <= zero_rd_d;
      range_err_q <= range_err_d;
      io_cap_q    <= io_cap_d;
      io_out_q    <= io_out_d;
      cpu_hold_q  <= cpu_hold_d;
      aux_hold_q  <= aux_hold_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign aux_gnt    = aux_gnt_s;
  assign cpu_rvalid = rd_pend_q & ~owner_q;
  assign aux_rvalid = rd_pend_q & owner_q;
  assign cpu_rdata  = cpu_rvalid ? resp_data_s : cpu_hold_q;
  assign aux_rdata  = aux_rvalid ? resp_data_s : aux_hold_q;
  assign io_out     = io_out_q;
`ifdef DMEM_RANGE_CHECK_EN
  assign range_err  = range_err_q;
`else
  logic unused_s;
  assign unused_s = range_err_q;
`endif

endmodule
